round_key_server: RTL and testbench
===================================

Name: round_key_server

Overview:
- Consumer side of the key schedule. Captures the full expanded key bus when the key expander signals done.
- Serves one 128-bit round key per handshake to the cipher/decipher round datapath.
- Forward order (round 0..NR) for encryption; reverse order (NR..0) for decryption.
- Decouples key expansion from round processing, so one schedule serves any number of blocks.

Parameters:
- size, 128, cipher key width in bits (128/192/256); NR = size/32+6; KW = 128*(NR+1) schedule width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- kall_in  in  KW  expanded schedule; round key i = kall_in[KW-1-128*i -:128]
- kall_done  in  1  level "schedule valid" from the expander; stays high once set
- start  in  1  request a key stream (sampled only in LOADED)
- decrypt  in  1  stream direction, sampled with start; 1 = reverse order
- rk_ready  in  1  consumer accepts rk this cycle
- rk_valid  out  1  rk is valid
- rk  out  128  current round key
- rk_index  out  4  round number of rk (0..NR)
- rk_last  out  1  high with the final key of the stream
- loaded  out  1  a schedule is held
- busy  out  1  stream in progress
- reload_err  out  1  one-cycle pulse: new schedule arrived during STREAM and was dropped

Behaviour:
- Reset (reset=0, async): state=EMPTY; held schedule cleared to 0; rk_valid=0, rk=0, rk_index=0, rk_last=0, loaded=0, busy=0, reload_err=0; kall_done edge detector cleared to 0.
- Capture:
  - Rising edge of kall_done (registered 0 -> 1) in EMPTY or LOADED copies kall_in into the internal schedule register. loaded=1 from the next cycle.
  - A level-high kall_done after reset counts as a rising edge in the first cycle.
- State EMPTY: start ignored. On capture -> LOADED.
- State LOADED:
  - Capture again overwrites the schedule and stays in LOADED.
  - start=1 -> STREAM. Latches decrypt; idx = 0 (enc) or NR (dec).
  - rk_valid=1 in the following cycle (1-cycle latency), with rk = key[idx] and rk_index=idx.
- State STREAM:
  - rk, rk_index, rk_last are registered and held stable while rk_valid && !rk_ready.
  - On handshake (rk_valid && rk_ready): idx steps +1 (enc) or -1 (dec), and the next key appears the next cycle with rk_valid staying 1 (one key per cycle at full throughput).
  - rk_last=1 when idx==NR (enc) or idx==0 (dec).
  - Handshake with rk_last=1: next cycle rk_valid=0, rk_last=0, busy=0, state -> LOADED. Schedule retained.
  - start ignored. decrypt changes are ignored mid-stream.
- Reload during STREAM: a kall_done rising edge is dropped (schedule unchanged) and reload_err pulses for 1 cycle. The stream continues with the old keys.
- start in the same cycle as a capture in LOADED: capture wins; start is ignored that cycle.
- busy=1 exactly when state==STREAM. loaded=1 in LOADED and STREAM.
- Reset mid-stream: immediate return to EMPTY, all outputs to reset values.
- Index arithmetic: 4-bit. NR<=14, so no wrap. Decrement never passes 0 because the stream terminates at idx 0.

Decomposition:
- Shared package: NR/KW derivation from size, state encoding (EMPTY/LOADED/STREAM), 128-bit round-key type.
- Sub-module rk_select (combinational mux: schedule, idx -> 128-bit key) is natural and reusable by the round datapath.
- FSM and registers stay in round_key_server.

Test Plan:
- Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c schedule, start with decrypt=0, rk_ready=1 -> rk_valid 1 cycle after start; rk sequence:
  - idx0 = 2b7e1516...4f3c
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1 on that beat
  - 11 beats total, then busy=0.
- Same schedule, decrypt=1 -> first beat rk_index=10 rk=d014f9a8..., last beat rk_index=0 rk=2b7e1516...4f3c with rk_last=1.
- Backpressure: toggle rk_ready 1/0 randomly -> rk and rk_index never change while rk_valid && !rk_ready; exactly 11 handshakes per stream.
- Reload during stream: pulse kall_done 0 -> 1 at beat 4 with a different schedule -> reload_err for 1 cycle; remaining beats use the old keys; the next stream also uses the old keys.
- size=256: start encrypt -> 15 beats (rk_index 0..14), rk_last on index 14.
- Assert reset=0 at beat 5 -> rk_valid, busy, loaded = 0 asynchronously. After release, start is ignored until kall_done rises again.

Source files
------------

// File: rtl/round_key_server_pkg.sv
// Shared definitions for the round-key server: schedule geometry derived from
// the cipher key width, FSM state encoding and the round-key type.
package round_key_server_pkg;

    localparam int RK_W = 128;

    typedef logic [RK_W-1:0] round_key_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Number of rounds for a 128/192/256-bit cipher key.
    function automatic int calc_nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int calc_kw(input int key_bits);
        return RK_W * (calc_nr(key_bits) + 1);
    endfunction

endpackage

// File: rtl/round_key_server_rk_select.sv
// Combinational round-key mux: picks key[idx] out of a packed schedule whose
// round 0 sits in the most significant 128 bits. Out-of-range idx yields 0.
module round_key_server_rk_select
    import round_key_server_pkg::*;
#(
    parameter int NR = 10,
    parameter int KW = RK_W * (NR + 1)
) (
    input  logic [KW-1:0]   i_sched,
    input  logic [3:0]      i_idx,
    output logic [RK_W-1:0] o_key
);

    always_comb begin
        o_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (i_idx == 4'(i)) begin
                o_key = i_sched[KW-1-RK_W*i -: RK_W];
            end
        end
    end

endmodule

// File: rtl/round_key_server.sv
// Holds one expanded key schedule and streams its round keys over a
// valid/ready port, forward for encryption and reverse for decryption.
module round_key_server
    import round_key_server_pkg::*;
#(
    parameter int size = 128,
    localparam int NR = calc_nr(size),
    localparam int KW = calc_kw(size)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [KW-1:0]   kall_in,
    input  logic            kall_done,
    input  logic            start,
    input  logic            decrypt,
    input  logic            rk_ready,
    output logic            rk_valid,
    output logic [127:0]    rk,
    output logic [3:0]      rk_index,
    output logic            rk_last,
    output logic            loaded,
    output logic            busy,
    output logic            reload_err,
    output logic [1:0]      dbg_state
);

    localparam logic [3:0] NR_IDX = 4'(NR);

    // rk port: rk/rk_index/rk_last are valid while rk_valid is high and hold
    // steady until the cycle rk_valid && rk_ready (handshake) is seen.

    state_t            r_state;
    state_t            w_state_next;
    logic              r_kd_q;
    logic [KW-1:0]     r_sched;
    logic              r_dec;
    logic              r_rk_valid;
    logic [RK_W-1:0]   r_rk;
    logic [3:0]        r_rk_index;
    logic              r_rk_last;
    logic              r_reload_err;

    logic              w_rise;
    logic              w_capture;
    logic              w_go;
    logic              w_hs;
    logic              w_dir;
    logic [3:0]        w_sel_idx;
    logic              w_sel_last;
    logic [RK_W-1:0]   w_sel_key;

    assign w_rise    = kall_done & ~r_kd_q;
    // A new schedule is only accepted while no stream depends on the old one.
    assign w_capture = w_rise && (r_state != ST_STREAM);
    assign w_go      = (r_state == ST_LOADED) && start && !w_capture;
    assign w_hs      = r_rk_valid && rk_ready;

    // Index of the key to present next: the stream's first key when starting,
    // otherwise one step on from the key currently shown.
    always_comb begin
        w_dir     = r_dec;
        w_sel_idx = r_dec ? (r_rk_index - 4'd1) : (r_rk_index + 4'd1);
        if (r_state == ST_LOADED) begin
            w_dir     = decrypt;
            w_sel_idx = decrypt ? NR_IDX : 4'd0;
        end
        w_sel_last = w_dir ? (w_sel_idx == 4'd0) : (w_sel_idx == NR_IDX);
    end

    round_key_server_rk_select #(
        .NR (NR),
        .KW (KW)
    ) u_rk_select (
        .i_sched (r_sched),
        .i_idx   (w_sel_idx),
        .o_key   (w_sel_key)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY:  if (w_capture) w_state_next = ST_LOADED;
            ST_LOADED: if (w_go) w_state_next = ST_STREAM;
            ST_STREAM: if (w_hs && r_rk_last) w_state_next = ST_LOADED;
            default:   w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kd_q       <= 1'b0;
            r_sched      <= '0;
            r_dec        <= 1'b0;
            r_rk_valid   <= 1'b0;
            r_rk         <= '0;
            r_rk_index   <= 4'd0;
            r_rk_last    <= 1'b0;
            r_reload_err <= 1'b0;
        end else begin
            r_kd_q       <= kall_done;
            r_reload_err <= w_rise && (r_state == ST_STREAM);
            if (w_capture) begin
                r_sched <= kall_in;
            end
            if (w_go) begin
                r_dec      <= decrypt;
                r_rk_valid <= 1'b1;
                r_rk       <= w_sel_key;
                r_rk_index <= w_sel_idx;
                r_rk_last  <= w_sel_last;
            end else if (w_hs) begin
                if (r_rk_last) begin
                    r_rk_valid <= 1'b0;
                    r_rk_last  <= 1'b0;
                end else begin
                    r_rk       <= w_sel_key;
                    r_rk_index <= w_sel_idx;
                    r_rk_last  <= w_sel_last;
                end
            end
        end
    end

    assign rk_valid   = r_rk_valid;
    assign rk         = r_rk;
    assign rk_index   = r_rk_index;
    assign rk_last    = r_rk_last;
    assign loaded     = (r_state != ST_EMPTY);
    assign busy       = (r_state == ST_STREAM);
    assign reload_err = r_reload_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_round_key_server.sv
// Directed bench for round_key_server: AES-128 schedule streaming both ways,
// backpressure, reload rejection, capture/start priority, reset, AES-256 length.
module tb_round_key_server;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            decrypt = 1'b0;
    logic            rk_ready = 1'b1;

    logic [1407:0]   kall128 = '0;
    logic            kd128 = 1'b0;
    logic            start128 = 1'b0;
    logic            v128, last128, loaded128, busy128, err128;
    logic [127:0]    rk128;
    logic [3:0]      idx128;
    logic [1:0]      st128;

    logic [1919:0]   kall256 = '0;
    logic            kd256 = 1'b0;
    logic            start256 = 1'b0;
    logic            v256, last256, loaded256, busy256, err256;
    logic [127:0]    rk256;
    logic [3:0]      idx256;
    logic [1:0]      st256;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_key [0:10];

    always #5 clk = ~clk;

    round_key_server #(.size(128)) u_dut128 (
        .clk(clk), .reset(reset), .kall_in(kall128), .kall_done(kd128),
        .start(start128), .decrypt(decrypt), .rk_ready(rk_ready),
        .rk_valid(v128), .rk(rk128), .rk_index(idx128), .rk_last(last128),
        .loaded(loaded128), .busy(busy128), .reload_err(err128), .dbg_state(st128)
    );

    round_key_server #(.size(256)) u_dut256 (
        .clk(clk), .reset(reset), .kall_in(kall256), .kall_done(kd256),
        .start(start256), .decrypt(decrypt), .rk_ready(rk_ready),
        .rk_valid(v256), .rk(rk256), .rk_index(idx256), .rk_last(last256),
        .loaded(loaded256), .busy(busy256), .reload_err(err256), .dbg_state(st256)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sched128(input logic invert);
        for (int i = 0; i <= 10; i++) begin
            kall128[1407-128*i -: 128] = invert ? ~exp_key[i] : exp_key[i];
        end
    endtask

    function automatic logic [127:0] key256(input int i);
        return {16{8'(i * 17)}};
    endfunction

    task automatic test_reset();
        tick();
        tick();
        checks++; if (v128 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", v128); end
        checks++; if (rk128 !== 128'h0) begin errors++; $display("FAIL reset_rk got %h want 0", rk128); end
        checks++; if (idx128 !== 4'd0 || last128 !== 1'b0) begin errors++; $display("FAIL reset_idx_last got %0d/%b want 0/0", idx128, last128); end
        checks++; if (loaded128 !== 1'b0 || busy128 !== 1'b0 || err128 !== 1'b0) begin
            errors++; $display("FAIL reset_flags got loaded=%b busy=%b err=%b want 0/0/0", loaded128, busy128, err128);
        end
        reset = 1'b1;
        tick();
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        tick();
        checks++; if (busy128 !== 1'b0 || v128 !== 1'b0) begin errors++; $display("FAIL empty_start got busy=%b valid=%b want 0/0", busy128, v128); end
    endtask

    task automatic test_load();
        set_sched128(1'b0);
        kd128 = 1'b1;
        tick();
        checks++; if (loaded128 !== 1'b1 || busy128 !== 1'b0 || v128 !== 1'b0) begin
            errors++; $display("FAIL load got loaded=%b busy=%b valid=%b want 1/0/0", loaded128, busy128, v128);
        end
    endtask

    task automatic test_encrypt();
        decrypt = 1'b0;
        rk_ready = 1'b1;
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            checks++; if (v128 !== 1'b1) begin errors++; $display("FAIL enc_valid beat %0d got %b want 1", b, v128); end
            checks++; if (rk128 !== exp_key[b]) begin errors++; $display("FAIL enc_key beat %0d got %h want %h", b, rk128, exp_key[b]); end
            checks++; if (idx128 !== 4'(b) || last128 !== (b == 10)) begin
                errors++; $display("FAIL enc_idx beat %0d got %0d/%b want %0d/%b", b, idx128, last128, b, (b == 10));
            end
            tick();
        end
        checks++; if (v128 !== 1'b0 || busy128 !== 1'b0 || loaded128 !== 1'b1 || last128 !== 1'b0) begin
            errors++; $display("FAIL enc_end got valid=%b busy=%b loaded=%b last=%b want 0/0/1/0", v128, busy128, loaded128, last128);
        end
    endtask

    task automatic test_decrypt();
        decrypt = 1'b1;
        rk_ready = 1'b1;
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        decrypt = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            checks++; if (v128 !== 1'b1 || rk128 !== exp_key[10-b]) begin
                errors++; $display("FAIL dec_key beat %0d got %b/%h want 1/%h", b, v128, rk128, exp_key[10-b]);
            end
            checks++; if (idx128 !== 4'(10 - b) || last128 !== (b == 10)) begin
                errors++; $display("FAIL dec_idx beat %0d got %0d/%b want %0d/%b", b, idx128, last128, 10 - b, (b == 10));
            end
            tick();
        end
        checks++; if (v128 !== 1'b0 || busy128 !== 1'b0) begin errors++; $display("FAIL dec_end got valid=%b busy=%b want 0/0", v128, busy128); end
    endtask

    task automatic test_backpressure();
        int hs;
        int exp_idx;
        int cycles;
        logic rdy;
        decrypt = 1'b0;
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        hs = 0;
        exp_idx = 0;
        cycles = 0;
        while (hs < 11 && cycles < 300) begin
            rdy = 1'($urandom_range(0, 1));
            rk_ready = rdy;
            checks++; if (v128 !== 1'b1 || rk128 !== exp_key[exp_idx] || idx128 !== 4'(exp_idx) || last128 !== (exp_idx == 10)) begin
                errors++; $display("FAIL bp_hold cycle %0d got %b/%0d/%b/%h want 1/%0d/%b/%h",
                                   cycles, v128, idx128, last128, rk128, exp_idx, (exp_idx == 10), exp_key[exp_idx]);
            end
            tick();
            cycles++;
            if (rdy) begin
                hs++;
                exp_idx++;
            end
        end
        rk_ready = 1'b1;
        checks++; if (hs != 11) begin errors++; $display("FAIL bp_count got %0d handshakes want 11", hs); end
        checks++; if (v128 !== 1'b0 || busy128 !== 1'b0) begin errors++; $display("FAIL bp_end got valid=%b busy=%b want 0/0", v128, busy128); end
    endtask

    task automatic test_reload();
        decrypt = 1'b0;
        rk_ready = 1'b1;
        kd128 = 1'b0;
        tick();
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            checks++; if (rk128 !== exp_key[b] || idx128 !== 4'(b)) begin
                errors++; $display("FAIL reload_key beat %0d got %0d/%h want %0d/%h", b, idx128, rk128, b, exp_key[b]);
            end
            checks++; if (err128 !== (b == 5)) begin errors++; $display("FAIL reload_err beat %0d got %b want %b", b, err128, (b == 5)); end
            if (b == 4) begin
                set_sched128(1'b1);
                kd128 = 1'b1;
            end
            tick();
        end
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            checks++; if (v128 !== 1'b1 || rk128 !== exp_key[b]) begin
                errors++; $display("FAIL reload_next beat %0d got %b/%h want 1/%h", b, v128, rk128, exp_key[b]);
            end
            tick();
        end
    endtask

    task automatic test_capture_and_reset();
        kd128 = 1'b0;
        tick();
        kd128 = 1'b1;
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        checks++; if (busy128 !== 1'b0 || loaded128 !== 1'b1 || v128 !== 1'b0) begin
            errors++; $display("FAIL cap_wins got busy=%b loaded=%b valid=%b want 0/1/0", busy128, loaded128, v128);
        end
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        checks++; if (rk128 !== ~exp_key[0]) begin errors++; $display("FAIL cap_new_key got %h want %h", rk128, ~exp_key[0]); end
        repeat (5) tick();
        checks++; if (idx128 !== 4'd5 || rk128 !== ~exp_key[5]) begin
            errors++; $display("FAIL mid_beat got %0d/%h want 5/%h", idx128, rk128, ~exp_key[5]);
        end
        reset = 1'b0;
        kd128 = 1'b0;
        #1;
        checks++; if (v128 !== 1'b0 || busy128 !== 1'b0 || loaded128 !== 1'b0) begin
            errors++; $display("FAIL async_reset got valid=%b busy=%b loaded=%b want 0/0/0", v128, busy128, loaded128);
        end
        checks++; if (rk128 !== 128'h0 || idx128 !== 4'd0) begin errors++; $display("FAIL async_reset_rk got %0d/%h want 0/0", idx128, rk128); end
        tick();
        reset = 1'b1;
        tick();
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        tick();
        checks++; if (busy128 !== 1'b0 || v128 !== 1'b0 || loaded128 !== 1'b0) begin
            errors++; $display("FAIL post_reset_start got busy=%b valid=%b loaded=%b want 0/0/0", busy128, v128, loaded128);
        end
        set_sched128(1'b0);
        kd128 = 1'b1;
        tick();
        checks++; if (loaded128 !== 1'b1) begin errors++; $display("FAIL post_reset_load got %b want 1", loaded128); end
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        checks++; if (v128 !== 1'b1 || rk128 !== exp_key[0]) begin
            errors++; $display("FAIL post_reset_stream got %b/%h want 1/%h", v128, rk128, exp_key[0]);
        end
    endtask

    task automatic test_size256();
        for (int i = 0; i <= 14; i++) begin
            kall256[1919-128*i -: 128] = key256(i);
        end
        kd256 = 1'b1;
        rk_ready = 1'b1;
        decrypt = 1'b0;
        tick();
        checks++; if (loaded256 !== 1'b1 || busy256 !== 1'b0) begin errors++; $display("FAIL k256_load got %b/%b want 1/0", loaded256, busy256); end
        start256 = 1'b1;
        tick();
        start256 = 1'b0;
        for (int b = 0; b <= 14; b++) begin
            checks++; if (v256 !== 1'b1 || rk256 !== key256(b)) begin
                errors++; $display("FAIL k256_key beat %0d got %b/%h want 1/%h", b, v256, rk256, key256(b));
            end
            checks++; if (idx256 !== 4'(b) || last256 !== (b == 14)) begin
                errors++; $display("FAIL k256_idx beat %0d got %0d/%b want %0d/%b", b, idx256, last256, b, (b == 14));
            end
            tick();
        end
        checks++; if (v256 !== 1'b0 || busy256 !== 1'b0) begin errors++; $display("FAIL k256_end got %b/%b want 0/0", v256, busy256); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_load();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reload();
        test_capture_and_reset();
        test_size256();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
